// File: rtl/bits_pkg.sv
// ---------------------------------------------------------------------------
// bits_pkg
// Shared constants and state type for the BITS packet parser.
//   TYPE_LITERAL  : packet type ID of a literal-value packet
//   HDR_BITS      : version + type field width
//   OPR_LEN0_BITS : operator header with 15-bit bit-length field
//   OPR_LEN1_BITS : operator header with 11-bit sub-packet count field
//   LIT_WINDOW    : width of the literal window handed to number_top
//   MIN_PKT_BITS  : smallest possible packet; fewer trailing bits are padding
// ---------------------------------------------------------------------------
package bits_pkg;

    localparam logic [2:0]  TYPE_LITERAL  = 3'd4;
    localparam int unsigned HDR_BITS      = 6;
    localparam int unsigned OPR_LEN0_BITS = 22;
    localparam int unsigned OPR_LEN1_BITS = 18;
    localparam int unsigned LIT_WINDOW    = 80;
    localparam int unsigned GROUP_BITS    = 5;
    localparam int unsigned MIN_PKT_BITS  = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_LIT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/bit_buffer.sv
// ---------------------------------------------------------------------------
// bit_buffer
// MSB-aligned bit queue: bits_o[BUF_W-1] is the next unread bit, the queue
// holds cnt_o bits and everything below them is zero.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (clears bits and count)
//   push_i     : append nibble_i this cycle
//   nibble_i   : 4 bits to append, MSB first
//   consume_i  : number of bits to drop from the head this cycle
//   bits_o     : buffer contents
//   cnt_o      : number of valid bits
// ---------------------------------------------------------------------------
module bit_buffer
    import bits_pkg::*;
#(
    parameter int unsigned BUF_W = 128,
    localparam int unsigned CNT_W = $clog2(BUF_W + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [3:0]       nibble_i,
    input  logic [6:0]       consume_i,
    output logic [BUF_W-1:0] bits_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [BUF_W-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cons_ext;
    logic [CNT_W-1:0] cons_eff;
    logic [CNT_W-1:0] base;
    logic [BUF_W-1:0] nib_ext;

    always_comb begin
        cons_ext = CNT_W'(consume_i);
        // Underrun after the last nibble: dropping more bits than are held
        // just empties the queue; the shift already supplies zeros.
        cons_eff = (cons_ext > cnt_q) ? cnt_q : cons_ext;
        base     = cnt_q - cons_eff;
        nib_ext  = {nibble_i, {(BUF_W-4){1'b0}}};
        bits_d   = bits_q << consume_i;
        cnt_d    = base;
        if (push_i) begin
            // New nibble lands directly behind the bits surviving this cycle.
            bits_d = bits_d | (nib_ext >> base);
            cnt_d  = base + CNT_W'(4);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bits_q <= '0;
            cnt_q  <= '0;
        end else begin
            bits_q <= bits_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bits_o = bits_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/bits_packet_parser.sv
// ---------------------------------------------------------------------------
// bits_packet_parser
// Accepts a BITS transmission one hex nibble per cycle, walks packet headers,
// hands 80-bit literal windows to number_top and drops the consumed groups.
//   clk, resetB          : clock, synchronous active-high reset
//   in_nibble/valid/last : nibble stream input, in_ready is the handshake
//   numberFromBits       : literal window (zero outside LIT)
//   enable               : literal strobe to number_top
//   validNibbles         : group-valid chain returned by number_top
//   pkt_hdr_valid        : header decode pulse
//   pkt_version/type/len_type/len : registered header fields
//   lit_groups           : group count of the last literal
//   version_sum          : running version sum (mod 2^16)
//   done                 : transmission fully parsed, sticky
// ---------------------------------------------------------------------------
module bits_packet_parser
    import bits_pkg::*;
#(
    parameter int unsigned BUF_W = 128
) (
    input  logic        clk,
    input  logic        resetB,
    input  logic [3:0]  in_nibble,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [79:0] numberFromBits,
    output logic        enable,
    input  logic [15:0] validNibbles,
    output logic        pkt_hdr_valid,
    output logic [2:0]  pkt_version,
    output logic [2:0]  pkt_type,
    output logic        pkt_len_type,
    output logic [14:0] pkt_len,
    output logic [4:0]  lit_groups,
    output logic [15:0] version_sum,
    output logic        done
);

    localparam int unsigned CNT_W = $clog2(BUF_W + 1);

    state_e           state_q, state_d;
    logic             ended_q;
    logic [2:0]       version_q;
    logic [2:0]       type_q;
    logic             len_type_q;
    logic [14:0]      len_q;
    logic [4:0]       lit_groups_q;
    logic [15:0]      version_sum_q;

    logic [BUF_W-1:0] bits;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             pad_end;
    logic             hdr_go;
    logic             lit_go;
    logic [2:0]       hdr_ver;
    logic [2:0]       hdr_type;
    logic             hdr_l;
    logic [4:0]       grp_cnt;
    logic [6:0]       consume;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    bit_buffer #(
        .BUF_W (BUF_W)
    ) u_bit_buffer (
        .clk_i     (clk),
        .rst_i     (resetB),
        .push_i    (accept),
        .nibble_i  (in_nibble),
        .consume_i (consume),
        .bits_o    (bits),
        .cnt_o     (cnt)
    );

    assign in_ready = (state_q != ST_DONE) && (cnt <= CNT_W'(BUF_W - 4));
    assign accept   = in_valid & in_ready;

    assign hdr_ver  = bits[BUF_W-1 -: 3];
    assign hdr_type = bits[BUF_W-4 -: 3];
    assign hdr_l    = bits[BUF_W-7];
    assign grp_cnt  = popcount16(validNibbles);

    always_comb begin
        // Once the stream has ended, a tail too short for any packet (or all
        // zero) is hex padding rather than another header.
        pad_end = ended_q && ((cnt < CNT_W'(MIN_PKT_BITS)) || (bits == '0));
        hdr_go  = (state_q == ST_HDR) && !pad_end &&
                  ((cnt >= CNT_W'(OPR_LEN0_BITS)) || ended_q);
        lit_go  = (state_q == ST_LIT) &&
                  ((cnt >= CNT_W'(LIT_WINDOW)) || ended_q);

        consume = '0;
        if (hdr_go) begin
            if (hdr_type == TYPE_LITERAL) begin
                consume = 7'(HDR_BITS);
            end else if (hdr_l) begin
                consume = 7'(OPR_LEN1_BITS);
            end else begin
                consume = 7'(OPR_LEN0_BITS);
            end
        end else if (lit_go) begin
            consume = 7'(grp_cnt) * 7'(GROUP_BITS);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_HDR;
            ST_HDR: begin
                if (pad_end) begin
                    state_d = ST_DONE;
                end else if (hdr_go && (hdr_type == TYPE_LITERAL)) begin
                    state_d = ST_LIT;
                end
            end
            ST_LIT:  if (lit_go) state_d = ST_HDR;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetB) begin
            state_q       <= ST_IDLE;
            ended_q       <= 1'b0;
            version_q     <= '0;
            type_q        <= '0;
            len_type_q    <= 1'b0;
            len_q         <= '0;
            lit_groups_q  <= '0;
            version_sum_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept && in_last) begin
                ended_q <= 1'b1;
            end
            if (hdr_go) begin
                version_q     <= hdr_ver;
                type_q        <= hdr_type;
                version_sum_q <= version_sum_q + 16'(hdr_ver);
                if (hdr_type == TYPE_LITERAL) begin
                    len_type_q <= 1'b0;
                    len_q      <= '0;
                end else begin
                    len_type_q <= hdr_l;
                    len_q      <= hdr_l ? {4'b0000, bits[BUF_W-8 -: 11]}
                                        : bits[BUF_W-8 -: 15];
                end
            end
            if (lit_go) begin
                lit_groups_q <= grp_cnt;
            end
        end
    end

    assign numberFromBits = (state_q == ST_LIT) ? bits[BUF_W-1 -: 80] : '0;
    assign enable         = lit_go;
    assign pkt_hdr_valid  = hdr_go;
    assign pkt_version    = version_q;
    assign pkt_type       = type_q;
    assign pkt_len_type   = len_type_q;
    assign pkt_len        = len_q;
    assign lit_groups     = lit_groups_q;
    assign version_sum    = version_sum_q;
    assign done           = (state_q == ST_DONE);

endmodule

// File: doc/bits_packet_parser.md
# bits_packet_parser

Upstream stage of `number_top`. It accepts the BITS transmission one hex nibble per cycle into a bit buffer and walks packet headers with an FSM. For literal packets it presents an 80-bit aligned window as `numberFromBits`, pulses `enable`, and uses the returned `validNibbles` chain to drop the exact number of consumed bits. For operator packets it reports the length fields. It also accumulates the version sum.

## Interface
Parameters:
- `BUF_W`, 128: bit-buffer width; must be ≥ 92 and a multiple of 4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetB`  in  1  synchronous reset, active-high.
- `in_nibble`  in  4  next hex digit; MSB is the first bit.
- `in_valid`  in  1  `in_nibble` is valid.
- `in_last`  in  1  qualifies the final nibble of the transmission.
- `in_ready`  out  1  nibble accepted when `in_valid & in_ready`.
- `numberFromBits`  out  80  `buf[BUF_W-1 -: 80]` while in LITERAL; 0 otherwise.
- `enable`  out  1  one-cycle strobe; `number_top` latches the literal on this strobe.
- `validNibbles`  in  16  group-valid chain returned combinationally by `number_top`.
- `pkt_hdr_valid`  out  1  one-cycle pulse; header fields below are valid.
- `pkt_version`  out  3  version field of the current packet.
- `pkt_type`  out  3  type ID of the current packet.
- `pkt_len_type`  out  1  operator length-type bit (0 = bit length, 1 = sub-packet count).
- `pkt_len`  out  15  operator length: 15-bit value, or 11-bit value zero-extended.
- `lit_groups`  out  5  number of 5-bit groups in the last literal (1..16).
- `version_sum`  out  16  running sum of all versions, wraps mod 2^16.
- `done`  out  1  transmission fully parsed; sticky until reset.

## Operation
- Buffer holds `cnt` bits, MSB-aligned: `buf[BUF_W-1]` is the next bit. Bits below `cnt` are zero.
- `in_ready = !done & (cnt <= BUF_W-4)`.
- An accepted nibble is appended at bit position `BUF_W-1-(cnt-consume)`.
- Same-cycle behaviour: `cnt_next = cnt - consume + 4*accept`. Accept and consume may happen in the same cycle.
- `ended` is set when `in_last` is accepted. It clears only on reset.
- States: IDLE → HDR → (LIT | OPR) → HDR … → DONE.
- **IDLE:** after reset; go to HDR on the first accepted nibble.
- **HDR:**
  - If `ended & (cnt < 11 | buf == 0)`: go to DONE (trailing padding).
  - Else wait until `cnt >= 22 | ended`, then decode `buf[BUF_W-1 -: 6]`.
  - Type 4: consume 6 bits, pulse `pkt_hdr_valid`, go to LIT.
  - Other types: read length-type bit `L`. Consume `7+15` bits (`L`=0) or `7+11` bits (`L`=1), pulse `pkt_hdr_valid`, stay in HDR.
  - Add the version to `version_sum` on the `pkt_hdr_valid` cycle.
- **LIT:**
  - Wait until `cnt >= 80 | ended`.
  - Then pulse `enable`. Set `g = popcount(validNibbles)`, consume `5*g` bits, set `lit_groups = g`, go to HDR.
- **DONE:** `in_ready = 0`, `done = 1`. Further inputs are ignored.
- **Underrun:** if `ended` and the required bits exceed `cnt`, the missing bits read as zero; parsing proceeds regardless.
- Reset in any state: buffer, `cnt`, and `ended` are cleared; FSM returns to IDLE. Any partial packet is discarded.

## Timing
- Reset values: `in_ready` = 1, `done` = 0, `enable` = 0, `pkt_hdr_valid` = 0.
- All other outputs reset to 0.
- `enable`, `pkt_hdr_valid`, and `in_ready` are combinational from registered state and `cnt`.
- Header fields, `lit_groups`, and `version_sum` are registered; they update on the edge that ends the pulse cycle.
- `numberFromBits` is stable through the `enable` cycle.
- `number_top.number` is valid one cycle after `enable`.
- Header decode takes 1 cycle once the bit threshold is met. A literal packet takes ≥ 2 cycles (HDR, LIT).

## Structure
- Shared package `bits_pkg`:
  - `TYPE_LITERAL = 3'd4`, `HDR_BITS = 6`, `OPR_LEN0_BITS = 22`, `OPR_LEN1_BITS = 18`, `LIT_WINDOW = 80`.
  - State enum.
- One sub-module: `bit_buffer`. It holds the shift register, the append/consume logic, and `cnt`.
- The FSM and popcount live in the top level.

## Test plan
- Stream `D2FE28` with `in_last` on the final nibble → `pkt_version` = 6, `pkt_type` = 4, `enable` pulses once, `number` = 2021, `lit_groups` = 3, then `done`.
- Stream `38006F45291200` → operator header (v1, t6, `L`=0, len 27), then literals 10 and 20; `version_sum` = 9.
- Stream `EE00D40C823060` → operator header (v7, t3, `L`=1, len 3), then literals 1, 2, 3; `version_sum` = 14.
- Stream `8A004A801A8002F478` with `in_valid` toggled randomly → `version_sum` = 16, `done` = 1, no nibble lost.
- Stream a long literal (16 groups) with `BUF_W` = 92 → `in_ready` deasserts when the buffer is full; the literal still decodes correctly.
- Assert `resetB` mid-LIT → all outputs return to reset values on the next cycle; restreaming `D2FE28` yields 2021.
